// File: rtl/sdcard_pkg.sv
// Shared types and constants for the SD command responder.
// crc7_step advances the serial CRC7 register by one bit.
package sdcard_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX       = 3'd1,
        CHECK    = 3'd2,
        WAIT_RSP = 3'd3,
        NCR      = 3'd4,
        TX       = 3'd5
    } state_e;

    localparam int          TOKEN_BITS  = 48;
    localparam int          NCR_CYCLES  = 2;
    localparam int          RSP_TIMEOUT = 64;
    localparam logic [6:0]  CRC7_POLY   = 7'h09;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sdcard_cmd_responder_if.sv
// Card-logic side of the responder: received command out, response handshake in.
// Signal suffixes are from the responder's point of view.
interface sdcard_cmd_responder_if;
    logic        cmd_valid_o;
    logic [5:0]  cmd_index_o;
    logic [31:0] cmd_arg_o;
    logic        rsp_valid_i;
    logic        rsp_ready_o;
    logic [5:0]  rsp_index_i;
    logic [31:0] rsp_status_i;

    modport slave (
        output cmd_valid_o, cmd_index_o, cmd_arg_o, rsp_ready_o,
        input  rsp_valid_i, rsp_index_i, rsp_status_i
    );

    modport master (
        input  cmd_valid_o, cmd_index_o, cmd_arg_o, rsp_ready_o,
        output rsp_valid_i, rsp_index_i, rsp_status_i
    );
endinterface

// File: rtl/sdcard_crc7.sv
// Serial CRC7 (x^7+x^3+1). Clear and enable together folds the bit into a zero register,
// so the first bit of a token can be absorbed on the same cycle the register is cleared.
module sdcard_crc7
    import sdcard_pkg::*;
(
    input  logic       PCLK_i,
    input  logic       PRESET_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);
    logic [6:0] crc_q, crc_d, base;

    always_comb begin
        base  = clr_i ? 7'd0 : crc_q;
        crc_d = en_i ? crc7_step(base, bit_i) : base;
    end

    always_ff @(posedge PCLK_i) begin
        if (PRESET_i) crc_q <= 7'd0;
        else          crc_q <= crc_d;
    end

    assign crc_o = crc_q;
endmodule

// File: rtl/sdcard_cmd_responder.sv
// SD card side CMD line engine: receives 48-bit command tokens, hands accepted
// commands to card logic, and serialises the 48-bit response after the NCR gap.
//
// state    | meaning
// IDLE     | line released, waiting for a start bit
// RX       | shifting in the remaining 47 token bits
// CHECK    | one cycle: validate transmission bit, CRC7 and end bit
// WAIT_RSP | offering rsp_ready_o, strobe-count timeout
// NCR      | line released for NCR_CYCLES strobes
// TX       | driving the response token, one bit per strobe
module sdcard_cmd_responder
    import sdcard_pkg::*;
(
    input  logic                  PCLK_i,
    input  logic                  PRESET_i,
    input  logic                  sd_clk_en_i,
    input  logic                  cmd_in_i,
    output logic                  cmd_out_o,
    output logic                  cmd_oe_o,
    output logic [7:0]            crc_err_count_o,
    output logic                  busy_o,
    sdcard_cmd_responder_if.slave rsp_if
);
    localparam logic [6:0] LAST_BIT = 7'(TOKEN_BITS - 1);
    localparam logic [6:0] NCR_LOAD = 7'(NCR_CYCLES);
    localparam logic [6:0] TO_LOAD  = 7'(RSP_TIMEOUT);

    state_e      state_q, state_d;
    logic [47:0] shift_q, shift_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        out_bit_q, out_bit_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic [7:0]  err_q, err_d;
    logic        crc_clr, crc_en, crc_bit;
    logic [6:0]  crc_val;
    logic        token_ok, handshake;

    sdcard_crc7 u_crc7 (
        .PCLK_i   (PCLK_i),
        .PRESET_i (PRESET_i),
        .clr_i    (crc_clr),
        .en_i     (crc_en),
        .bit_i    (crc_bit),
        .crc_o    (crc_val)
    );

    assign token_ok  = shift_q[46] && (crc_val == shift_q[7:1]) && shift_q[0];
    assign handshake = rsp_if.rsp_valid_i && (state_q == WAIT_RSP);

    always_ff @(posedge PCLK_i) begin
        if (PRESET_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (sd_clk_en_i && !cmd_in_i) state_d = RX;
            RX:       if (sd_clk_en_i && cnt_q == 7'd1) state_d = CHECK;
            CHECK:    state_d = token_ok ? WAIT_RSP : IDLE;
            WAIT_RSP: if (handshake) state_d = NCR;
                      else if (sd_clk_en_i && cnt_q == 7'd1) state_d = IDLE;
            NCR:      if (sd_clk_en_i && cnt_q == 7'd1) state_d = TX;
            TX:       if (sd_clk_en_i && cnt_q == 7'd0) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o             = (state_q != IDLE);
        rsp_if.rsp_ready_o = (state_q == WAIT_RSP);
        cmd_oe_o           = (state_q == TX);
        cmd_out_o          = cmd_oe_o ? out_bit_q : 1'b1;
    end

    // cnt_q is the down-counter for every state: bits left in RX/TX, strobes left otherwise
    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        out_bit_d   = out_bit_q;
        cmd_valid_d = 1'b0;
        cmd_index_d = cmd_index_q;
        cmd_arg_d   = cmd_arg_q;
        err_d       = err_q;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        crc_bit     = cmd_in_i;
        case (state_q)
            IDLE: begin
                crc_clr = 1'b1;
                if (sd_clk_en_i && !cmd_in_i) begin
                    shift_d = '0;
                    cnt_d   = LAST_BIT;
                    crc_en  = 1'b1;
                end
            end
            RX: if (sd_clk_en_i) begin
                shift_d = {shift_q[46:0], cmd_in_i};
                cnt_d   = cnt_q - 7'd1;
                crc_en  = (cnt_q > 7'd8);
            end
            CHECK: begin
                if (token_ok) begin
                    cmd_valid_d = 1'b1;
                    cmd_index_d = shift_q[45:40];
                    cmd_arg_d   = shift_q[39:8];
                    cnt_d       = TO_LOAD;
                end else if (err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
            end
            WAIT_RSP: begin
                if (handshake) begin
                    shift_d = {2'b00, rsp_if.rsp_index_i, rsp_if.rsp_status_i, 8'h01};
                    cnt_d   = NCR_LOAD;
                end else if (sd_clk_en_i) begin
                    cnt_d = cnt_q - 7'd1;
                end
            end
            NCR: if (sd_clk_en_i) begin
                if (cnt_q == 7'd1) begin
                    out_bit_d = shift_q[47];
                    shift_d   = {shift_q[46:0], 1'b0};
                    cnt_d     = LAST_BIT;
                    crc_clr   = 1'b1;
                    crc_en    = 1'b1;
                    crc_bit   = shift_q[47];
                end else begin
                    cnt_d = cnt_q - 7'd1;
                end
            end
            TX: if (sd_clk_en_i) begin
                if (cnt_q == 7'd0) begin
                    out_bit_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q > 7'd8) begin
                        out_bit_d = shift_q[47];
                        shift_d   = {shift_q[46:0], 1'b0};
                        crc_en    = 1'b1;
                        crc_bit   = shift_q[47];
                    end else if (cnt_q > 7'd1) begin
                        out_bit_d = crc_val[3'(cnt_q - 7'd2)];
                    end else begin
                        out_bit_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK_i) begin
        if (PRESET_i) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            out_bit_q   <= 1'b1;
            cmd_valid_q <= 1'b0;
            cmd_index_q <= '0;
            cmd_arg_q   <= '0;
            err_q       <= '0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            out_bit_q   <= out_bit_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_index_q <= cmd_index_d;
            cmd_arg_q   <= cmd_arg_d;
            err_q       <= err_d;
        end
    end

    assign rsp_if.cmd_valid_o = cmd_valid_q;
    assign rsp_if.cmd_index_o = cmd_index_q;
    assign rsp_if.cmd_arg_o   = cmd_arg_q;
    assign crc_err_count_o    = err_q;
endmodule

// File: tb/tb_sdcard_cmd_responder.sv
// Self-checking bench for sdcard_cmd_responder: directed SD tokens plus randomized
// tokens against a polynomial-division CRC7 model and a token-level scoreboard.
module tb_sdcard_cmd_responder;

    logic       PCLK_i = 1'b0;
    logic       PRESET_i = 1'b1;
    logic       sd_clk_en_i = 1'b0;
    logic       cmd_in_i = 1'b1;
    logic       cmd_out_o, cmd_oe_o, busy_o;
    logic [7:0] crc_err_count_o;

    sdcard_cmd_responder_if bus ();

    sdcard_cmd_responder dut (
        .PCLK_i          (PCLK_i),
        .PRESET_i        (PRESET_i),
        .sd_clk_en_i     (sd_clk_en_i),
        .cmd_in_i        (cmd_in_i),
        .cmd_out_o       (cmd_out_o),
        .cmd_oe_o        (cmd_oe_o),
        .crc_err_count_o (crc_err_count_o),
        .busy_o          (busy_o),
        .rsp_if          (bus)
    );

    always #5 PCLK_i = ~PCLK_i;

    int          total = 0;
    int          bad = 0;
    int          n_valid = 0;
    int          line_bad = 0;
    int          max_gap = 2;
    logic [5:0]  cap_idx = '0;
    logic [31:0] cap_arg = '0;
    logic        last_oe, last_out;
    int          exp_err;
    logic [5:0]  exp_idx;
    logic [31:0] exp_arg;

    // pulse monitor: records every cycle cmd_valid_o is high and the fields seen with it
    always @(negedge PCLK_i) begin
        if (bus.cmd_valid_o === 1'b1) begin
            n_valid = n_valid + 1;
            cap_idx = bus.cmd_index_o;
            cap_arg = bus.cmd_arg_o;
        end
    end

    // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1 (long division)
    function automatic logic [6:0] ref_crc7(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [47:0] mk_tok(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, ref_crc7(h), 1'b1};
    endfunction

    function automatic logic accept_rule(input logic [47:0] t);
        return (t[46] === 1'b1) && (t[7:1] === ref_crc7(t[47:8])) && (t[0] === 1'b1);
    endfunction

    task automatic strobe(input logic b);
        @(negedge PCLK_i);
        last_oe  = cmd_oe_o;
        last_out = cmd_out_o;
        if (cmd_oe_o === 1'b0 && cmd_out_o !== 1'b1) line_bad++;
        cmd_in_i    = b;
        sd_clk_en_i = 1'b1;
        @(negedge PCLK_i);
        sd_clk_en_i = 1'b0;
        repeat ($urandom_range(0, max_gap)) @(negedge PCLK_i);
    endtask

    task automatic send_token(input logic [47:0] tok);
        for (int i = 47; i >= 0; i--) strobe(tok[i]);
        cmd_in_i = 1'b1;
        repeat (3) @(negedge PCLK_i);
    endtask

    task automatic apply_reset();
        @(negedge PCLK_i);
        PRESET_i = 1'b1;
        sd_clk_en_i = 1'b0;
        cmd_in_i = 1'b1;
        bus.rsp_valid_i = 1'b0;
        repeat (3) @(negedge PCLK_i);
        PRESET_i = 1'b0;
        n_valid = 0;
        exp_err = 0;
        exp_idx = '0;
        exp_arg = '0;
        @(negedge PCLK_i);
    endtask

    task automatic do_handshake(input logic [5:0] idx, input logic [31:0] st);
        int w;
        w = 0;
        while (bus.rsp_ready_o !== 1'b1 && w < 20) begin
            @(negedge PCLK_i);
            w++;
        end
        total++;
        if (w >= 20) begin
            bad++;
            $display("FAIL hs_wait: rsp_ready_o=%b, expected 1 within 20 cycles", bus.rsp_ready_o);
        end
        repeat ($urandom_range(0, 3)) @(negedge PCLK_i);
        bus.rsp_valid_i  = 1'b1;
        bus.rsp_index_i  = idx;
        bus.rsp_status_i = st;
        @(negedge PCLK_i);
        bus.rsp_valid_i  = 1'b0;
        bus.rsp_index_i  = ~idx;
        bus.rsp_status_i = ~st;
    endtask

    // drives the NCR gap and the 48 response bits with random CMD input, then checks the line
    task automatic tx_check(input logic [5:0] idx, input logic [31:0] st);
        logic [47:0] got, expv;
        logic [39:0] h;
        int ncr_bad, oe_bad;
        ncr_bad = 0;
        oe_bad = 0;
        got = '0;
        h = {2'b00, idx, st};
        expv = {h, ref_crc7(h), 1'b1};
        for (int k = 0; k < 2; k++) begin
            strobe(1'($urandom_range(0, 1)));
            if (last_oe !== 1'b0 || last_out !== 1'b1) ncr_bad++;
        end
        for (int k = 47; k >= 0; k--) begin
            strobe(1'($urandom_range(0, 1)));
            got[k] = last_out;
            if (last_oe !== 1'b1) oe_bad++;
        end
        strobe(1'b1);
        total++;
        if (ncr_bad != 0) begin bad++; $display("FAIL tx_ncr_gap: %0d gap periods driven, expected 0", ncr_bad); end
        total++;
        if (oe_bad != 0) begin bad++; $display("FAIL tx_oe: %0d bit periods without oe, expected 0", oe_bad); end
        total++;
        if (got !== expv) begin bad++; $display("FAIL tx_bits: got %012h expected %012h", got, expv); end
        total++;
        if (last_oe !== 1'b0 || last_out !== 1'b1) begin
            bad++; $display("FAIL tx_release: oe=%b out=%b expected oe=0 out=1", last_oe, last_out);
        end
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL tx_idle: busy_o=%b expected 0", busy_o); end
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (cmd_out_o !== 1'b1) begin bad++; $display("FAIL rst_out: %b expected 1", cmd_out_o); end
        total++; if (cmd_oe_o !== 1'b0) begin bad++; $display("FAIL rst_oe: %b expected 0", cmd_oe_o); end
        total++; if (bus.cmd_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: %b expected 0", bus.cmd_valid_o); end
        total++; if (bus.rsp_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready: %b expected 0", bus.rsp_ready_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: %b expected 0", busy_o); end
        total++; if (bus.cmd_index_o !== 6'd0) begin bad++; $display("FAIL rst_index: %0d expected 0", bus.cmd_index_o); end
        total++; if (bus.cmd_arg_o !== 32'd0) begin bad++; $display("FAIL rst_arg: %h expected 0", bus.cmd_arg_o); end
        total++; if (crc_err_count_o !== 8'd0) begin bad++; $display("FAIL rst_err: %0d expected 0", crc_err_count_o); end
    endtask

    task automatic test_cmd0();
        apply_reset();
        bus.rsp_index_i = 6'h3F;
        bus.rsp_status_i = 32'hFFFF_FFFF;
        send_token(48'h4000_0000_0095);
        total++; if (n_valid != 1) begin bad++; $display("FAIL cmd0_pulse: %0d pulse cycles, expected 1", n_valid); end
        total++; if (cap_idx !== 6'd0) begin bad++; $display("FAIL cmd0_index: %0d expected 0", cap_idx); end
        total++; if (cap_arg !== 32'd0) begin bad++; $display("FAIL cmd0_arg: %h expected 0", cap_arg); end
        total++; if (bus.rsp_ready_o !== 1'b1) begin bad++; $display("FAIL cmd0_ready: %b expected 1", bus.rsp_ready_o); end
    endtask

    task automatic test_cmd17_tx();
        apply_reset();
        send_token(48'h5100_0000_0055);
        total++; if (n_valid != 1) begin bad++; $display("FAIL cmd17_pulse: %0d expected 1", n_valid); end
        total++; if (cap_idx !== 6'd17) begin bad++; $display("FAIL cmd17_index: %0d expected 17", cap_idx); end
        total++; if (cap_arg !== 32'd0) begin bad++; $display("FAIL cmd17_arg: %h expected 0", cap_arg); end
        do_handshake(6'd17, 32'h0000_0900);
        tx_check(6'd17, 32'h0000_0900);
        total++; if (n_valid != 1) begin bad++; $display("FAIL cmd17_no_rx_in_tx: %0d pulses expected 1", n_valid); end
    endtask

    task automatic test_crc_err();
        apply_reset();
        send_token(48'h4800_0001_AA87 ^ 48'h8);
        total++; if (n_valid != 0) begin bad++; $display("FAIL cmd8_bad_pulse: %0d expected 0", n_valid); end
        total++; if (crc_err_count_o !== 8'd1) begin bad++; $display("FAIL cmd8_err_cnt: %0d expected 1", crc_err_count_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL cmd8_idle: busy_o=%b expected 0", busy_o); end
        send_token(48'h4800_0001_AA87);
        total++; if (n_valid != 1 || cap_idx !== 6'd8 || cap_arg !== 32'h1AA) begin
            bad++; $display("FAIL cmd8_good: pulses=%0d idx=%0d arg=%h expected 1/8/000001aa", n_valid, cap_idx, cap_arg);
        end
        total++; if (crc_err_count_o !== 8'd1) begin bad++; $display("FAIL cmd8_err_hold: %0d expected 1", crc_err_count_o); end
    endtask

    task automatic test_timeout();
        int oe_seen;
        oe_seen = 0;
        apply_reset();
        send_token(mk_tok(6'd55, 32'h0));
        total++; if (n_valid != 1 || cap_idx !== 6'd55) begin
            bad++; $display("FAIL cmd55_rx: pulses=%0d idx=%0d expected 1/55", n_valid, cap_idx);
        end
        for (int k = 0; k < 63; k++) begin
            strobe(1'($urandom_range(0, 1)));
            if (last_oe !== 1'b0 || cmd_oe_o !== 1'b0) oe_seen++;
        end
        total++; if (bus.rsp_ready_o !== 1'b1) begin bad++; $display("FAIL to_early: ready=%b after 63 strobes expected 1", bus.rsp_ready_o); end
        strobe(1'b1);
        total++; if (bus.rsp_ready_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL to_drop: ready=%b busy=%b after 64 strobes expected 0/0", bus.rsp_ready_o, busy_o);
        end
        total++; if (oe_seen != 0 || cmd_oe_o !== 1'b0) begin bad++; $display("FAIL to_oe: %0d driven samples expected 0", oe_seen); end
    endtask

    task automatic test_reset_mid_tx();
        apply_reset();
        send_token(mk_tok(6'd17, 32'h1234));
        do_handshake(6'd17, 32'hDEAD_BEEF);
        for (int k = 0; k < 22; k++) strobe(1'b1);
        total++; if (cmd_oe_o !== 1'b1) begin bad++; $display("FAIL midtx_driving: oe=%b expected 1", cmd_oe_o); end
        PRESET_i = 1'b1;
        @(posedge PCLK_i);
        #1;
        total++; if (cmd_oe_o !== 1'b0 || cmd_out_o !== 1'b1) begin
            bad++; $display("FAIL midtx_release: oe=%b out=%b expected 0/1", cmd_oe_o, cmd_out_o);
        end
        total++; if (busy_o !== 1'b0 || bus.rsp_ready_o !== 1'b0 || bus.cmd_valid_o !== 1'b0 ||
                     bus.cmd_index_o !== 6'd0 || bus.cmd_arg_o !== 32'd0 || crc_err_count_o !== 8'd0) begin
            bad++; $display("FAIL midtx_outputs: busy=%b rdy=%b vld=%b idx=%0d arg=%h err=%0d expected all 0",
                            busy_o, bus.rsp_ready_o, bus.cmd_valid_o, bus.cmd_index_o, bus.cmd_arg_o, crc_err_count_o);
        end
        @(negedge PCLK_i);
        PRESET_i = 1'b0;
    endtask

    task automatic test_reset_mid_rx();
        logic [47:0] tok;
        apply_reset();
        tok = mk_tok(6'd9, 32'hCAFE_0001);
        for (int i = 47; i >= 24; i--) strobe(tok[i]);
        PRESET_i = 1'b1;
        @(posedge PCLK_i);
        #1;
        total++; if (busy_o !== 1'b0 || cmd_oe_o !== 1'b0 || cmd_out_o !== 1'b1) begin
            bad++; $display("FAIL midrx_reset: busy=%b oe=%b out=%b expected 0/0/1", busy_o, cmd_oe_o, cmd_out_o);
        end
        @(negedge PCLK_i);
        PRESET_i = 1'b0;
        for (int k = 0; k < 30; k++) strobe(1'b1);
        repeat (3) @(negedge PCLK_i);
        total++; if (n_valid != 0 || crc_err_count_o !== 8'd0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL midrx_partial: pulses=%0d err=%0d busy=%b expected 0/0/0", n_valid, crc_err_count_o, busy_o);
        end
    endtask

    task automatic test_random();
        int exp_valid, m;
        logic [47:0] tok;
        logic [39:0] h;
        logic [5:0] idx, ridx;
        logic [31:0] arg, rst_v;
        logic acc;
        apply_reset();
        exp_valid = 0;
        for (int it = 0; it < 24; it++) begin
            idx = 6'($urandom_range(0, 63));
            arg = $urandom;
            m = $urandom_range(0, 5);
            tok = mk_tok(idx, arg);
            if (m == 1) tok = tok ^ (48'd1 << $urandom_range(0, 46));
            else if (m == 2) begin h = {2'b00, idx, arg}; tok = {h, ref_crc7(h), 1'b1}; end
            else if (m == 3) tok[0] = 1'b0;
            acc = accept_rule(tok);
            send_token(tok);
            if (acc) begin
                exp_valid++;
                exp_idx = tok[45:40];
                exp_arg = tok[39:8];
            end else if (exp_err < 255) begin
                exp_err++;
            end
            total++; if (n_valid != exp_valid) begin bad++; $display("FAIL rnd_pulses[%0d]: %0d expected %0d", it, n_valid, exp_valid); end
            total++; if (bus.cmd_index_o !== exp_idx || bus.cmd_arg_o !== exp_arg) begin
                bad++; $display("FAIL rnd_fields[%0d]: idx=%0d arg=%h expected %0d/%h", it, bus.cmd_index_o, bus.cmd_arg_o, exp_idx, exp_arg);
            end
            total++; if (crc_err_count_o !== 8'(exp_err)) begin bad++; $display("FAIL rnd_err[%0d]: %0d expected %0d", it, crc_err_count_o, exp_err); end
            if (acc) begin
                total++; if (cap_idx !== exp_idx || cap_arg !== exp_arg) begin
                    bad++; $display("FAIL rnd_pulse_fields[%0d]: idx=%0d arg=%h expected %0d/%h", it, cap_idx, cap_arg, exp_idx, exp_arg);
                end
                ridx = 6'($urandom_range(0, 63));
                rst_v = $urandom;
                do_handshake(ridx, rst_v);
                tx_check(ridx, rst_v);
            end else begin
                total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rnd_reject_idle[%0d]: busy=%b expected 0", it, busy_o); end
            end
        end
    endtask

    task automatic test_saturate();
        logic [47:0] tok;
        apply_reset();
        max_gap = 0;
        for (int it = 0; it < 300; it++) begin
            tok = mk_tok(6'($urandom_range(0, 63)), $urandom) ^ (48'd1 << $urandom_range(0, 46));
            if (!accept_rule(tok) && exp_err < 255) exp_err++;
            send_token(tok);
        end
        max_gap = 2;
        total++; if (crc_err_count_o !== 8'(exp_err) || crc_err_count_o !== 8'hFF) begin
            bad++; $display("FAIL sat_err: %0d expected %0d (255)", crc_err_count_o, exp_err);
        end
        total++; if (n_valid != 0) begin bad++; $display("FAIL sat_pulses: %0d expected 0", n_valid); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rsp_valid_i  = 1'b0;
        bus.rsp_index_i  = '0;
        bus.rsp_status_i = '0;
        exp_err = 0;
        exp_idx = '0;
        exp_arg = '0;
        test_reset();
        test_cmd0();
        test_cmd17_tx();
        test_crc_err();
        test_timeout();
        test_reset_mid_tx();
        test_reset_mid_rx();
        test_random();
        test_saturate();
        total++;
        if (line_bad != 0) begin bad++; $display("FAIL line_idle_high: %0d released samples not 1, expected 0", line_bad); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
